// File: rtl/mc_mem_responder.sv
// mc_mem_responder: word-addressed memory responder with a valid/ready request and
// response handshake and a fixed number of wait states between accept and commit.
// Optional feature macro: MEM_RANGE_CHK_EN. When defined, requests whose upper address
// bits are non-zero complete with rsp_err_o = 1, zero read data and no write. When it is
// undefined, upper address bits are ignored and addresses alias.
module mc_mem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [15:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    localparam int unsigned Depth = 1 << ADDR_W;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                err_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         mem_q [Depth];

    logic                accept;
    logic                commit;
    logic                req_err;
    logic                c_we;
    logic                c_err;
    logic [ADDR_W-1:0]   c_addr;
    logic [31:0]         c_wdata;

`ifdef MEM_RANGE_CHK_EN
    assign req_err = (req_addr_i >> ADDR_W) != 16'd0;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[15:ADDR_W];
    assign req_err        = 1'b0;
`endif

    assign accept = (state_q == StIdle) && req_valid_i;

    // State register and wait counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; also decides the edge on which the access commits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (LATENCY == 0) begin
                        commit  = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StWait;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // With zero wait states the access commits on the accept edge, so it uses the live
    // request; otherwise it uses the copy latched at accept.
    always_comb begin
        if (LATENCY == 0) begin
            c_we    = req_we_i;
            c_addr  = req_addr_i[ADDR_W-1:0];
            c_wdata = req_wdata_i;
            c_err   = req_err;
        end else begin
            c_we    = we_q;
            c_addr  = addr_q;
            c_wdata = wdata_q;
            c_err   = err_q;
        end
    end

    // Request capture at the accept edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i[ADDR_W-1:0];
            wdata_q <= req_wdata_i;
            err_q   <= req_err;
        end
    end

    // Storage array; not reset. Gated by rst_ni so no write lands while reset is held.
    always_ff @(posedge clk_i) begin
        if (commit && c_we && !c_err && rst_ni) begin
            mem_q[c_addr] <= c_wdata;
        end
    end

    // Response next-state: load on commit, hold until the response handshake.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = c_err;
            if (c_err) begin
                rsp_rdata_d = 32'd0;
            end else if (c_we) begin
                rsp_rdata_d = c_wdata;
            end else begin
                rsp_rdata_d = mem_q[c_addr];
            end
        end else if (rsp_valid_q && rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Outputs: flops or a decode of the state register only.
    always_comb begin
        req_ready_o = (state_q == StIdle);
        busy_o      = (state_q != StIdle);
        rsp_valid_o = rsp_valid_q;
        rsp_rdata_o = rsp_rdata_q;
        rsp_err_o   = rsp_err_q;
    end

endmodule

// File: tb/tb_mc_mem_responder.sv
// Bench for mc_mem_responder: three instances (LATENCY 2, 0, 4) share one clock. A
// transaction-level model predicts outputs every cycle; directed tests pin literal values.
module tb_mc_mem_responder;

    localparam int NI = 3;
    localparam int unsigned LAT0 = 2;
    localparam int unsigned LAT1 = 0;
    localparam int unsigned LAT2 = 4;

    logic clk = 1'b0;
    logic [NI-1:0] rst_n;
    logic [NI-1:0] req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_err, busy;
    logic [15:0]   req_addr  [NI];
    logic [31:0]   req_wdata [NI];
    logic [31:0]   rsp_rdata [NI];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? LAT0 : (g == 1) ? LAT1 : LAT2;
        mc_mem_responder #(.ADDR_W(8), .LATENCY(L)) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_n[g]),
            .req_valid_i (req_valid[g]),
            .req_ready_o (req_ready[g]),
            .req_we_i    (req_we[g]),
            .req_addr_i  (req_addr[g]),
            .req_wdata_i (req_wdata[g]),
            .rsp_valid_o (rsp_valid[g]),
            .rsp_ready_i (rsp_ready[g]),
            .rsp_rdata_o (rsp_rdata[g]),
            .rsp_err_o   (rsp_err[g]),
            .busy_o      (busy[g])
        );
    end

    function automatic int lat_of(input int i);
        return (i == 0) ? int'(LAT0) : (i == 1) ? int'(LAT1) : int'(LAT2);
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h want %h", nm, i, act, exp);
        end
    endtask

    // ---------------- transaction model ----------------
    // phase: 0 = free, 1 = access pending, 2 = response outstanding
    int          m_phase [NI];
    int          m_left  [NI];
    logic        m_we    [NI];
    logic [15:0] m_addr  [NI];
    logic [31:0] m_wd    [NI];
    logic [31:0] m_rdata [NI];
    logic        m_err   [NI];
    bit          m_rknown[NI];
    logic [31:0] m_mem   [NI][256];
    bit          m_kn    [NI][256];

    function automatic void model_commit(input int i);
        logic [7:0] idx;
        bit         oob;
        idx = m_addr[i][7:0];
`ifdef MEM_RANGE_CHK_EN
        oob = (m_addr[i] >= 16'd256);
`else
        oob = 1'b0;
`endif
        m_err[i] = oob;
        if (oob) begin
            m_rdata[i]  = 32'd0;
            m_rknown[i] = 1'b1;
        end else if (m_we[i]) begin
            m_mem[i][idx] = m_wd[i];
            m_kn[i][idx]  = 1'b1;
            m_rdata[i]    = m_wd[i];
            m_rknown[i]   = 1'b1;
        end else begin
            m_rdata[i]  = m_mem[i][idx];
            m_rknown[i] = m_kn[i][idx];
        end
        m_phase[i] = 2;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n[i]) begin
                m_phase[i] = 0;
            end else begin
                case (m_phase[i])
                    0: if (req_valid[i]) begin
                        m_we[i]   = req_we[i];
                        m_addr[i] = req_addr[i];
                        m_wd[i]   = req_wdata[i];
                        m_left[i] = lat_of(i);
                        if (m_left[i] == 0) model_commit(i);
                        else m_phase[i] = 1;
                    end
                    1: begin
                        m_left[i]--;
                        if (m_left[i] == 0) model_commit(i);
                    end
                    default: if (rsp_ready[i]) m_phase[i] = 0;
                endcase
            end
        end
    end

    // Per-cycle compare against the model, just after each active edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NI; i++) begin
            if (rst_n[i]) begin
                chk("req_ready", i, 32'(req_ready[i]), 32'(m_phase[i] == 0));
                chk("busy", i, 32'(busy[i]), 32'(m_phase[i] != 0));
                chk("rsp_valid", i, 32'(rsp_valid[i]), 32'(m_phase[i] == 2));
                if (m_phase[i] == 2) begin
                    chk("rsp_err", i, 32'(rsp_err[i]), 32'(m_err[i]));
                    if (m_rknown[i]) chk("rsp_rdata", i, rsp_rdata[i], m_rdata[i]);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_rsp(input int i, output logic [31:0] rd, output logic er,
                            output int lat, output int low);
        lat = 0;
        low = 0;
        forever begin
            if (!req_ready[i]) low++;
            if (rsp_valid[i] || lat >= 50) break;
            @(negedge clk);
            lat++;
        end
        if (lat >= 50) chk("rsp_timeout", i, 32'd0, 32'd1);
        rd = rsp_rdata[i];
        er = rsp_err[i];
    endtask

    task automatic req_go(input int i, input logic we, input logic [15:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic er,
                          output int lat, output int low);
        int n;
        @(negedge clk);
        req_valid[i] = 1'b1;
        req_we[i]    = we;
        req_addr[i]  = a;
        req_wdata[i] = wd;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", i, 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Garbage on the request bus after accept must be ignored.
        req_valid[i] = 1'b0;
        req_we[i]    = 1'($urandom);
        req_addr[i]  = 16'($urandom);
        req_wdata[i] = $urandom;
        wait_rsp(i, rd, er, lat, low);
    endtask

    task automatic wait_idle(input int i, inout int low);
        int n;
        n = 0;
        while (!req_ready[i] && n < 50) begin
            @(negedge clk);
            n++;
            if (!req_ready[i]) low++;
        end
        if (n >= 50) chk("idle_timeout", i, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, low;

        rst_n     = '1;
        req_valid = '0;
        req_we    = '0;
        rsp_ready = '1;
        for (int i = 0; i < NI; i++) begin
            req_addr[i]  = 16'd0;
            req_wdata[i] = 32'd0;
        end
        #2 rst_n = '0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_rsp_valid", i, 32'(rsp_valid[i]), 32'd0);
            chk("rst_rsp_rdata", i, rsp_rdata[i], 32'd0);
            chk("rst_rsp_err", i, 32'(rsp_err[i]), 32'd0);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_req_ready", i, 32'(req_ready[i]), 32'd1);
        end
        repeat (2) @(negedge clk);
        rst_n = '1;

        // Basic write then read, LATENCY=2.
        req_go(0, 1'b1, 16'h0005, 32'hDEADBEEF, rd, er, lat, low);
        chk("wr_lat", 0, 32'(lat), 32'd2);
        chk("wr_rdata", 0, rd, 32'hDEADBEEF);
        chk("wr_err", 0, 32'(er), 32'd0);
        wait_idle(0, low);
        chk("wr_ready_low", 0, 32'(low), 32'd3);
        req_go(0, 1'b0, 16'h0005, 32'h0, rd, er, lat, low);
        chk("rd_lat", 0, 32'(lat), 32'd2);
        chk("rd_rdata", 0, rd, 32'hDEADBEEF);
        wait_idle(0, low);
        chk("rd_ready_low", 0, 32'(low), 32'd3);

        // Back-pressure: response held for 5 cycles with a new request waiting.
        rsp_ready[0] = 1'b0;
        req_go(0, 1'b0, 16'h0005, 32'h0, rd, er, lat, low);
        chk("bp_rd", 0, rd, 32'hDEADBEEF);
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b0;
        req_addr[0]  = 16'h0005;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 0, 32'(rsp_valid[0]), 32'd1);
            chk("bp_rdata", 0, rsp_rdata[0], 32'hDEADBEEF);
            chk("bp_ready", 0, 32'(req_ready[0]), 32'd0);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_hs_valid", 0, 32'(rsp_valid[0]), 32'd0);
        chk("bp_hs_ready", 0, 32'(req_ready[0]), 32'd1);
        @(negedge clk);
        chk("bp_next_accepted", 0, 32'(req_ready[0]), 32'd0);
        req_valid[0] = 1'b0;
        wait_rsp(0, rd, er, lat, low);
        chk("bp_next_lat", 0, 32'(lat), 32'd2);
        chk("bp_next_rdata", 0, rd, 32'hDEADBEEF);
        wait_idle(0, low);

        // LATENCY=0.
        req_go(1, 1'b1, 16'h0001, 32'h12345678, rd, er, lat, low);
        chk("l0_wr_lat", 1, 32'(lat), 32'd0);
        chk("l0_wr_rdata", 1, rd, 32'h12345678);
        wait_idle(1, low);
        req_go(1, 1'b0, 16'h0001, 32'h0, rd, er, lat, low);
        chk("l0_rd_lat", 1, 32'(lat), 32'd0);
        chk("l0_rd_rdata", 1, rd, 32'h12345678);
        wait_idle(1, low);
        chk("l0_ready_low", 1, 32'(low), 32'd1);

        // Reset mid-WAIT, LATENCY=4.
        req_go(2, 1'b1, 16'h0003, 32'h11111111, rd, er, lat, low);
        chk("l4_init_lat", 2, 32'(lat), 32'd4);
        wait_idle(2, low);
        chk("l4_ready_low", 2, 32'(low), 32'd5);
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_we[2]    = 1'b1;
        req_addr[2]  = 16'h0003;
        req_wdata[2] = 32'hAAAA5555;
        chk("l4_pre_ready", 2, 32'(req_ready[2]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n[2] = 1'b0;
        #1;
        chk("mid_rst_valid", 2, 32'(rsp_valid[2]), 32'd0);
        chk("mid_rst_rdata", 2, rsp_rdata[2], 32'd0);
        chk("mid_rst_err", 2, 32'(rsp_err[2]), 32'd0);
        chk("mid_rst_busy", 2, 32'(busy[2]), 32'd0);
        repeat (2) @(negedge clk);
        rst_n[2] = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 2, 32'(req_ready[2]), 32'd1);
        req_go(2, 1'b0, 16'h0003, 32'h0, rd, er, lat, low);
        chk("post_rst_rdata", 2, rd, 32'h11111111);
        wait_idle(2, low);

        // Alias / range check.
        req_go(0, 1'b1, 16'h0007, 32'h01234567, rd, er, lat, low);
        wait_idle(0, low);
        req_go(0, 1'b1, 16'h0107, 32'hCAFEF00D, rd, er, lat, low);
`ifdef MEM_RANGE_CHK_EN
        chk("oob_wr_err", 0, 32'(er), 32'd1);
        chk("oob_wr_rdata", 0, rd, 32'd0);
`else
        chk("alias_wr_err", 0, 32'(er), 32'd0);
        chk("alias_wr_rdata", 0, rd, 32'hCAFEF00D);
`endif
        wait_idle(0, low);
        req_go(0, 1'b0, 16'h0007, 32'h0, rd, er, lat, low);
        chk("alias_rd_err", 0, 32'(er), 32'd0);
`ifdef MEM_RANGE_CHK_EN
        chk("alias_rd_rdata", 0, rd, 32'h01234567);
`else
        chk("alias_rd_rdata", 0, rd, 32'hCAFEF00D);
`endif
        wait_idle(0, low);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_mem_responder.md
# mc_mem_responder

Word-addressed memory responder that serves the memory side of the multi-cycle CPU's load/store/fetch traffic through a valid/ready request and response handshake with a configurable number of wait states. It holds a 2^ADDR_W × 32 storage array. Each accepted request completes after LATENCY cycles with one response beat. It sits between the CPU datapath's address/write-data outputs and its instruction/data registers, replacing the zero-wait memory so that a stalling controller can be exercised.

## Interface
Parameters:
- ADDR_W, 8 — storage depth is 2^ADDR_W words; only req_addr[ADDR_W-1:0] indexes the array.
- LATENCY, 2 — wait cycles from request acceptance to the access commit; legal range 0..15.

Ports:
- clk  in  1  — single clock; all state changes on its rising edge.
- reset  in  1  — asynchronous, active-low reset.
- req_valid  in  1  — a request is present.
- req_ready  out  1  — the responder can accept a request this cycle.
- req_we  in  1  — 1 = write, 0 = read.
- req_addr  in  16  — word address, the same width as the CPU memory address.
- req_wdata  in  32  — write data.
- rsp_valid  out  1  — a response is present.
- rsp_ready  in  1  — the CPU accepts the response.
- rsp_rdata  out  32  — read data; for a write, the data that was written.
- rsp_err  out  1  — address out of range (see Configuration); tied 0 when the feature is compiled out.
- busy  out  1  — high whenever the state is not IDLE.

## Operation
- There are three states: IDLE, WAIT and RESP. In IDLE, req_ready = 1; in WAIT and RESP, req_ready = 0.
- Accept: in IDLE, when req_valid && req_ready at a rising edge, the responder latches we, addr and wdata.
  - If LATENCY == 0, the access commits on that same edge and the state goes to RESP.
  - Otherwise the state goes to WAIT with cnt = LATENCY-1.
- WAIT:
  - If cnt == 0, the access commits and the state goes to RESP.
  - Otherwise cnt decrements.
- Commit:
  - Write: array[addr] <= wdata, and rsp_rdata <= wdata.
  - Read: rsp_rdata <= array[addr].
- RESP: rsp_valid = 1 and rsp_rdata/rsp_err are held stable until rsp_valid && rsp_ready at an edge. The state then goes to IDLE.
- A new request can be accepted no earlier than the cycle after the response handshake. There is no overlap of request and response.
- Request inputs outside the accept edge are ignored. Changing them during WAIT has no effect.
- Upper address bits (req_addr[15:ADDR_W]) are ignored unless MEM_RANGE_CHK_EN is defined, so addresses alias modulo 2^ADDR_W.
- Reset (reset low, at any time including mid-transaction):
  - The state goes to IDLE immediately; cnt = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, busy = 0.
  - A write still in WAIT is discarded and is never committed.
  - Array contents are not reset.

## Timing
- Accept at edge k → rsp_valid is high from just after edge k+LATENCY. The earliest response handshake is at edge k+LATENCY+1.
- Minimum transaction period is LATENCY+2 cycles: accept edge, LATENCY cycles of waiting, response edge.
- With rsp_ready held high, rsp_valid is high for exactly one cycle.
- Outputs are registered: rsp_valid, rsp_rdata and rsp_err come from flops. req_ready and busy decode the state register only.
- There is no combinational path from any input to any output.
- A read of the address written by the previous transaction returns the new data.

## Configuration
- MEM_RANGE_CHK_EN defined:
  - A request with req_addr[15:ADDR_W] != 0 is handled as an error.
  - It still takes LATENCY cycles and produces one response.
  - The response carries rsp_err = 1 and rsp_rdata = 0, and the write is suppressed.
  - In-range requests give rsp_err = 0.
- MEM_RANGE_CHK_EN undefined:
  - No check is made; addresses alias.
  - rsp_err is constant 0.

## Test plan
- Basic write then read, LATENCY=2, rsp_ready=1:
  - Stimulus: write 0xDEADBEEF to addr 0x0005, then read 0x0005.
  - Response: each rsp_valid pulse appears 2 cycles after accept; the read returns 0xDEADBEEF; req_ready is 0 for 3 cycles per transaction.
- Back-pressure:
  - Stimulus: hold rsp_ready=0 for 5 cycles after a read response appears.
  - Response: rsp_valid and rsp_rdata stay constant; req_ready stays 0 with req_valid=1; the next request is accepted the cycle after rsp_ready=1.
- LATENCY=0:
  - Stimulus: write 0x12345678 to addr 0x0001, then read it back.
  - Response: rsp_valid is high the cycle after accept; the read returns 0x12345678.
- Reset mid-WAIT, LATENCY=4:
  - Stimulus: write 0xAAAA5555 to addr 3 after addr 3 was initialised to 0x11111111; pull reset low 2 cycles after accept.
  - Response: all outputs go to 0 and req_ready goes to 1 after release; a later read of addr 3 returns 0x11111111.
- Alias/range, ADDR_W=8:
  - Stimulus: write 0xCAFEF00D to addr 0x0107, then read addr 0x0007.
  - Response without the macro: the read returns 0xCAFEF00D with rsp_err=0.
  - Response with MEM_RANGE_CHK_EN: the write response has rsp_err=1 and rdata 0, and the read of 0x0007 returns the prior contents.
